// File: rtl/tick_gen.sv
// Runtime-programmable clock-enable generator: one-cycle tick per period plus an exact-period
// square clk_out, with glitch-free divisor reload, pause and phase restart.
module tick_gen #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 100
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             sync_clr_i,
  input  logic             div_load_i,
  input  logic [CNT_W-1:0] div_val_i,
  output logic             tick_o,
  output logic             clk_out_o,
  output logic             div_pending_o,
  output logic             div_err_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam longint unsigned MaxDiv = (64'd1 << CNT_W) - 64'd1;

  if (CNT_W < 2 || CNT_W > 63) begin : gen_bad_width
    $error("tick_gen: CNT_W must be in 2..63");
  end
  if (DEFAULT_DIV < 2 || longint'(DEFAULT_DIV) > MaxDiv) begin : gen_bad_default
    $error("tick_gen: DEFAULT_DIV must be in 2..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);
  localparam logic [CNT_W-1:0] One    = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_div_q, pend_div_d;
  logic             pend_v_q, pend_v_d;
  logic             tick_q, tick_d;
  logic             clk_out_q, clk_out_d;
  logic             div_err_q, div_err_d;

  logic             clamp;
  logic [CNT_W-1:0] eff_div;
  logic             boundary;
  logic [CNT_W-1:0] next_div;

  always_comb begin
    clamp    = div_val_i < MinDiv;
    eff_div  = clamp ? MinDiv : div_val_i;
    boundary = en_i && (cnt_q == (cur_div_q - One));
    // Divisor for a period that starts on this edge: a same-edge load beats the pending value.
    if (div_load_i) begin
      next_div = eff_div;
    end else if (pend_v_q) begin
      next_div = pend_div_q;
    end else begin
      next_div = cur_div_q;
    end
  end

  always_comb begin
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_v_d   = pend_v_q;
    tick_d     = 1'b0;
    clk_out_d  = clk_out_q;
    div_err_d  = div_load_i && clamp;

    if (sync_clr_i) begin
      cnt_d     = '0;
      cur_div_d = next_div;
      pend_v_d  = 1'b0;
      clk_out_d = 1'b0;
      if (div_load_i) begin
        pend_div_d = eff_div;
      end
    end else if (boundary) begin
      cnt_d     = '0;
      tick_d    = 1'b1;
      cur_div_d = next_div;
      pend_v_d  = 1'b0;
      if (div_load_i) begin
        pend_div_d = eff_div;
      end
    end else begin
      if (en_i) begin
        cnt_d = cnt_q + One;
      end
      if (div_load_i) begin
        pend_div_d = eff_div;
        pend_v_d   = 1'b1;
      end
    end

    // Low for ceil(D/2) phases, high for floor(D/2): exact period for odd and even D.
    if (!sync_clr_i && en_i) begin
      clk_out_d = cnt_d >= (cur_div_d - (cur_div_d >> 1));
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      cur_div_q  <= DefDiv;
      pend_div_q <= DefDiv;
      pend_v_q   <= 1'b0;
      tick_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      div_err_q  <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_v_q   <= pend_v_d;
      tick_q     <= tick_d;
      clk_out_q  <= clk_out_d;
      div_err_q  <= div_err_d;
    end
  end

  assign tick_o        = tick_q;
  assign clk_out_o     = clk_out_q;
  assign div_pending_o = pend_v_q;
  assign div_err_o     = div_err_q;
  assign cnt_o         = cnt_q;

endmodule
